// File: rtl/radix2_bf_64_if.sv
// Stream, delay-line feedback and result signals of the span-64 SDF butterfly.
// The slave modport is the butterfly's view; the master modport is its environment.
interface radix2_bf_64_if #(
    parameter int DW = 24,
    parameter int CW = 7
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] din_r;
    logic [DW-1:0] din_i;
    logic [DW-1:0] delay_r;
    logic [DW-1:0] delay_i;
    logic          fb_valid;
    logic [DW-1:0] fb_r;
    logic [DW-1:0] fb_i;
    logic          out_valid;
    logic [DW-1:0] dout_r;
    logic [DW-1:0] dout_i;
    logic [CW-1:0] frame_cnt;

    modport slave (
        input  in_valid, din_r, din_i, delay_r, delay_i,
        output in_ready, fb_valid, fb_r, fb_i, out_valid, dout_r, dout_i, frame_cnt
    );

    modport master (
        output in_valid, din_r, din_i, delay_r, delay_i,
        input  in_ready, fb_valid, fb_r, fb_i, out_valid, dout_r, dout_i, frame_cnt
    );
endinterface

// File: rtl/radix2_bf_64.sv
// Radix-2 single-delay-feedback butterfly stage, span HALF (64) of the 512-pt FFT.
// Works in a loop with an external HALF-deep delay line: fb_* feeds the line,
// delay_* is its output. The first half of each frame is parked in the line;
// the second half produces sums (sent out) and differences (parked in the line,
// sent out during the next frame's first half or while flushing).
module radix2_bf_64 #(
    parameter int DW    = 24,
    parameter int HALF  = 64,
    parameter bit SCALE = 1'b1
) (
    input logic            clk,
    input logic            rst,
    radix2_bf_64_if.slave  bus
);
    localparam int CW = $clog2(2 * HALF);
    localparam logic [CW-1:0] CNT_HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_ONE       = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN,
        FLUSH
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] dout_r_q, dout_r_d;
    logic [DW-1:0] dout_i_q, dout_i_d;

    logic          in_ready_c;
    logic          accept;
    logic          second_half;
    logic          fb_valid_c;
    logic [DW-1:0] fb_r_c, fb_i_c;
    logic [DW:0]   sum_r, sum_i, dif_r, dif_i;

    // Reduce a DW+1-bit result back to DW bits: halve (floor) or saturate.
    function automatic logic [DW-1:0] trim(input logic [DW:0] x);
        logic [DW-1:0] r;
        if (SCALE) begin
            r = x[DW:1];
        end else if (x[DW] != x[DW-1]) begin
            r = x[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end else begin
            r = x[DW-1:0];
        end
        return r;
    endfunction

    assign in_ready_c  = (state_q != FLUSH);
    assign accept      = bus.in_valid & in_ready_c;
    assign second_half = cnt_q[CW-1];

    assign sum_r = {bus.delay_r[DW-1], bus.delay_r} + {bus.din_r[DW-1], bus.din_r};
    assign sum_i = {bus.delay_i[DW-1], bus.delay_i} + {bus.din_i[DW-1], bus.din_i};
    assign dif_r = {bus.delay_r[DW-1], bus.delay_r} - {bus.din_r[DW-1], bus.din_r};
    assign dif_i = {bus.delay_i[DW-1], bus.delay_i} - {bus.din_i[DW-1], bus.din_i};

    // Next state, frame counter, feedback path and next output values.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = 1'b0;
        dout_r_d    = dout_r_q;
        dout_i_d    = dout_i_q;
        fb_valid_c  = 1'b0;
        fb_r_c      = bus.din_r;
        fb_i_c      = bus.din_i;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    fb_valid_c = 1'b1;
                    cnt_d      = cnt_q + CNT_ONE;
                    state_d    = FILL;
                end
            end

            FILL: begin
                if (accept) begin
                    fb_valid_c = 1'b1;
                    cnt_d      = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_HALF_LAST) begin
                        state_d = RUN;
                    end
                end
            end

            RUN: begin
                if (accept) begin
                    fb_valid_c  = 1'b1;
                    cnt_d       = cnt_q + CNT_ONE;
                    out_valid_d = 1'b1;
                    if (second_half) begin
                        dout_r_d = trim(sum_r);
                        dout_i_d = trim(sum_i);
                        fb_r_c   = trim(dif_r);
                        fb_i_c   = trim(dif_i);
                    end else begin
                        dout_r_d = bus.delay_r;
                        dout_i_d = bus.delay_i;
                    end
                end else if (cnt_q == '0) begin
                    state_d = FLUSH;
                end
            end

            FLUSH: begin
                fb_valid_c  = 1'b1;
                fb_r_c      = '0;
                fb_i_c      = '0;
                out_valid_d = 1'b1;
                dout_r_d    = bus.delay_r;
                dout_i_d    = bus.delay_i;
                if (cnt_q == CNT_HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and registered outputs; reset discards any partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            dout_r_q    <= '0;
            dout_i_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            dout_r_q    <= dout_r_d;
            dout_i_q    <= dout_i_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.fb_valid  = fb_valid_c;
    assign bus.fb_r      = fb_r_c;
    assign bus.fb_i      = fb_i_c;
    assign bus.out_valid = out_valid_q;
    assign bus.dout_r    = dout_r_q;
    assign bus.dout_i    = dout_i_q;
    assign bus.frame_cnt = cnt_q;
endmodule

// File: tb/tb_radix2_bf_64.sv
// Directed bench for radix2_bf_64: a scaling instance runs in a loop with a
// behavioural 64-deep delay line; a saturating instance shares its stream
// but takes its delay input straight from the bench to hit the clamps.
module tb_radix2_bf_64;
    localparam int DW   = 24;
    localparam int HALF = 64;

    logic clk = 1'b0;
    logic rst;
    logic [DW-1:0] sat_delay_r;

    int checks = 0;
    int errors = 0;

    logic          obs_fb_valid;
    logic [DW-1:0] obs_fb_r;
    logic          obs_in_ready;
    logic [DW-1:0] obs_sat_fb_r;

    logic [DW-1:0] dl_r [HALF];
    logic [DW-1:0] dl_i [HALF];

    radix2_bf_64_if #(.DW(DW)) bus ();
    radix2_bf_64_if #(.DW(DW)) bus_s ();

    radix2_bf_64 #(.DW(DW), .HALF(HALF), .SCALE(1'b1)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    radix2_bf_64 #(.DW(DW), .HALF(HALF), .SCALE(1'b0)) u_dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Behavioural delay line closing the feedback loop of the scaling instance.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < HALF; k++) begin
                dl_r[k] <= '0;
                dl_i[k] <= '0;
            end
        end else if (bus.fb_valid) begin
            dl_r[0] <= bus.fb_r;
            dl_i[0] <= bus.fb_i;
            for (int k = 1; k < HALF; k++) begin
                dl_r[k] <= dl_r[k-1];
                dl_i[k] <= dl_i[k-1];
            end
        end
    end

    assign bus.delay_r    = dl_r[HALF-1];
    assign bus.delay_i    = dl_i[HALF-1];
    assign bus_s.in_valid = bus.in_valid;
    assign bus_s.din_r    = bus.din_r;
    assign bus_s.din_i    = bus.din_i;
    assign bus_s.delay_r  = sat_delay_r;
    assign bus_s.delay_i  = '0;

    // Count one comparison and report it when it does not hold.
    task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of input at the falling edge, capture the combinational
    // feedback mid-cycle, then return just after the rising edge.
    task automatic applyStimulus(input logic v, input logic [DW-1:0] r, input logic [DW-1:0] i);
        @(negedge clk);
        bus.in_valid = v;
        bus.din_r    = r;
        bus.din_i    = i;
        #1;
        obs_fb_valid = bus.fb_valid;
        obs_fb_r     = bus.fb_r;
        obs_in_ready = bus.in_ready;
        obs_sat_fb_r = bus_s.fb_r;
        @(posedge clk);
        #1;
    endtask

    // Ramp frame x[n]=n with an optional stall, then the 64-cycle flush.
    // Sums are ((n-64)+n)>>1 = n-32; every parked difference is -64>>1 = -32.
    task automatic runRampFrame(input string tag, input int stall_at, input int stall_len);
        for (int n = 0; n < 2*HALF; n++) begin
            if (stall_len > 0 && n == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    applyStimulus(1'b0, '0, '0);
                    checkOutput({tag, "_stall_cnt"}, DW'(bus.frame_cnt), DW'(stall_at));
                    checkOutput({tag, "_stall_fbv"}, DW'(obs_fb_valid), DW'(0));
                    checkOutput({tag, "_stall_ov"}, DW'(bus.out_valid), DW'(0));
                end
            end
            applyStimulus(1'b1, DW'(n), '0);
            checkOutput({tag, "_cnt"}, DW'(bus.frame_cnt), DW'((n + 1) % (2*HALF)));
            checkOutput({tag, "_fbv"}, DW'(obs_fb_valid), DW'(1));
            if (n < HALF) begin
                checkOutput({tag, "_fill_ov"}, DW'(bus.out_valid), DW'(0));
                checkOutput({tag, "_fill_fb"}, obs_fb_r, DW'(n));
            end else begin
                checkOutput({tag, "_sum_ov"}, DW'(bus.out_valid), DW'(1));
                checkOutput({tag, "_sum_r"}, bus.dout_r, DW'(n - 32));
                checkOutput({tag, "_sum_i"}, bus.dout_i, DW'(0));
                checkOutput({tag, "_dif_fb"}, obs_fb_r, DW'(-32));
            end
        end
        applyStimulus(1'b0, '0, '0);
        checkOutput({tag, "_bound_rdy"}, DW'(obs_in_ready), DW'(1));
        for (int k = 0; k < HALF; k++) begin
            applyStimulus(1'b0, '0, '0);
            checkOutput({tag, "_fl_rdy"}, DW'(obs_in_ready), DW'(0));
            checkOutput({tag, "_fl_fbv"}, DW'(obs_fb_valid), DW'(1));
            checkOutput({tag, "_fl_fb"}, obs_fb_r, DW'(0));
            checkOutput({tag, "_fl_ov"}, DW'(bus.out_valid), DW'(1));
            checkOutput({tag, "_fl_dout"}, bus.dout_r, DW'(-32));
        end
        checkOutput({tag, "_idle_rdy"}, DW'(bus.in_ready), DW'(1));
        checkOutput({tag, "_idle_cnt"}, DW'(bus.frame_cnt), DW'(0));
        applyStimulus(1'b0, '0, '0);
        checkOutput({tag, "_idle_ov"}, DW'(bus.out_valid), DW'(0));
    endtask

    // Hard stop in case the run never reaches its summary.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        int outs;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.din_r    = '0;
        bus.din_i    = '0;
        sat_delay_r  = '0;

        $display("[TB] test 1: reset then idle");
        repeat (3) @(negedge clk);
        checkOutput("rst_ov", DW'(bus.out_valid), DW'(0));
        checkOutput("rst_dout", bus.dout_r, DW'(0));
        checkOutput("rst_rdy", DW'(bus.in_ready), DW'(1));
        checkOutput("rst_cnt", DW'(bus.frame_cnt), DW'(0));
        checkOutput("rst_fbv", DW'(bus.fb_valid), DW'(0));
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            applyStimulus(1'b0, '0, '0);
            checkOutput("idle_ov", DW'(bus.out_valid), DW'(0));
            checkOutput("idle_fbv", DW'(obs_fb_valid), DW'(0));
            checkOutput("idle_dout", bus.dout_r, DW'(0));
            checkOutput("idle_rdy", DW'(obs_in_ready), DW'(1));
        end

        $display("[TB] test 2: single ramp frame");
        runRampFrame("t2", 0, 0);

        $display("[TB] test 3: three back-to-back frames of 100+0j");
        outs = 0;
        for (int f = 0; f < 3; f++) begin
            for (int n = 0; n < 2*HALF; n++) begin
                applyStimulus(1'b1, DW'(100), '0);
                if (f == 0 && n < HALF) begin
                    checkOutput("t3_fill_ov", DW'(bus.out_valid), DW'(0));
                end else begin
                    outs++;
                    checkOutput("t3_ov", DW'(bus.out_valid), DW'(1));
                    checkOutput("t3_dout", bus.dout_r, (n >= HALF) ? DW'(100) : DW'(0));
                    checkOutput("t3_fb", obs_fb_r, (n >= HALF) ? DW'(0) : DW'(100));
                end
            end
        end
        checkOutput("t3_outs", DW'(outs), DW'(320));
        applyStimulus(1'b0, '0, '0);
        for (int k = 0; k < HALF; k++) begin
            applyStimulus(1'b0, '0, '0);
            checkOutput("t3_fl_ov", DW'(bus.out_valid), DW'(1));
            checkOutput("t3_fl_dout", bus.dout_r, DW'(0));
        end
        checkOutput("t3_idle_rdy", DW'(bus.in_ready), DW'(1));

        $display("[TB] test 4: five-cycle stall at cnt 70");
        runRampFrame("t4", 70, 5);

        $display("[TB] test 5: saturation");
        for (int n = 0; n < HALF; n++) begin
            applyStimulus(1'b1, 24'h7FFFFF, '0);
        end
        sat_delay_r = 24'h7FFFFF;
        applyStimulus(1'b1, 24'h7FFFFF, '0);
        checkOutput("t5_sat_sum_pos", bus_s.dout_r, 24'h7FFFFF);
        checkOutput("t5_sat_fb_zero", obs_sat_fb_r, 24'h000000);
        checkOutput("t5_scl_sum", bus.dout_r, 24'h7FFFFF);
        checkOutput("t5_scl_fb_zero", obs_fb_r, 24'h000000);
        applyStimulus(1'b1, 24'h800000, '0);
        checkOutput("t5_sat_dif_pos", obs_sat_fb_r, 24'h7FFFFF);
        checkOutput("t5_sat_sum_m1", bus_s.dout_r, 24'hFFFFFF);
        checkOutput("t5_scl_dif", obs_fb_r, 24'h7FFFFF);
        checkOutput("t5_scl_sum_m1", bus.dout_r, 24'hFFFFFF);
        sat_delay_r = 24'h800000;
        applyStimulus(1'b1, 24'h800000, '0);
        checkOutput("t5_sat_sum_neg", bus_s.dout_r, 24'h800000);
        checkOutput("t5_sat_fb_zero2", obs_sat_fb_r, 24'h000000);
        sat_delay_r = '0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] test 6: reset at cnt 90");
        for (int n = 0; n < 90; n++) begin
            applyStimulus(1'b1, DW'(n), '0);
        end
        checkOutput("t6_pre_cnt", DW'(bus.frame_cnt), DW'(90));
        checkOutput("t6_pre_ov", DW'(bus.out_valid), DW'(1));
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        #1;
        checkOutput("t6_rst_ov", DW'(bus.out_valid), DW'(0));
        checkOutput("t6_rst_cnt", DW'(bus.frame_cnt), DW'(0));
        checkOutput("t6_rst_rdy", DW'(bus.in_ready), DW'(1));
        checkOutput("t6_rst_fbv", DW'(bus.fb_valid), DW'(0));
        checkOutput("t6_rst_dout", bus.dout_r, DW'(0));
        @(negedge clk);
        rst = 1'b0;
        runRampFrame("t6", 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
